// File: rtl/pair_check_scheduler.sv
// pair_check_scheduler
//   Round-robin scheduler that shares one 2-bit pair-check lane among N_REQ
//   requesters. The winner holds the lane for BURST symbols. During that time
//   its symbol is routed to x_out and "pair" symbols (2'b00 / 2'b11) are counted.
//   Each burst ends with a one-cycle done pulse.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   req        per-requester request level, held for the whole burst
//   x_bus      requester i symbol = x_bus[2i+1:2i]
//   gnt        registered one-hot grant
//   x_out      selected symbol while busy, 2'b00 otherwise
//   busy       high while a burst is running
//   done       one-cycle pulse when a burst ends
//   abort      qualifies done: burst ended because the requester dropped req
//   done_id    id of the burst that just finished
//   match_cnt  saturating pair count of the current / last burst
module pair_check_scheduler #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int BURST = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] x_bus,
  output logic [N_REQ-1:0]   gnt,
  output logic [1:0]         x_out,
  output logic               busy,
  output logic               done,
  output logic               abort,
  output logic [ID_W-1:0]    done_id,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int BEAT_W = $clog2(BURST + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   id;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic [BEAT_W-1:0] beat;
  logic              abort_q;
  logic [1:0]        sym;
  logic              req_held;
  logic              burst_end;
  int                idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] v);
    return (v == ID_W'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Symbol and request of the granted requester, selected by the registered id.
  assign sym       = x_bus[2*int'(id) +: 2];
  assign req_held  = req[int'(id)];
  assign burst_end = (beat == BEAT_LAST);

  // Round-robin search starting at rr_ptr; the first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = RUN;
      RUN:     if (!req_held || burst_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN);
    done  = (state == DONE);
    abort = (state == DONE) && abort_q;
    x_out = (state == RUN) ? sym : 2'b00;
  end

  // A dropped request takes priority over the normal end of a burst, and the
  // symbol seen in the cycle where the drop happens is not counted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt       <= '0;
      id        <= '0;
      rr_ptr    <= '0;
      beat      <= '0;
      abort_q   <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            id        <= win_id;
            gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
            beat      <= '0;
            match_cnt <= '0;
          end
        end
        RUN: begin
          if (!req_held) begin
            gnt     <= '0;
            abort_q <= 1'b1;
            done_id <= id;
          end else begin
            beat <= beat + 1'b1;
            if (sym[1] == sym[0]) match_cnt <= sat_inc(match_cnt);
            if (burst_end) begin
              gnt     <= '0;
              abort_q <= 1'b0;
              done_id <= id;
            end
          end
        end
        DONE: rr_ptr <= next_ptr(id);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_check_scheduler.sv
module tb_pair_check_scheduler;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req;
  logic [7:0] x_bus;
  logic [3:0] gnt;
  logic [1:0] x_out;
  logic       busy, done, abort;
  logic [1:0] done_id;
  logic [3:0] match_cnt;

  logic [3:0] gnt_s;
  logic [1:0] x_out_s;
  logic       busy_s, done_s, abort_s;
  logic [1:0] done_id_s;
  logic [1:0] match_cnt_s;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pair_check_scheduler #(.N_REQ(4), .ID_W(2), .BURST(8), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .req(req), .x_bus(x_bus),
    .gnt(gnt), .x_out(x_out), .busy(busy), .done(done), .abort(abort),
    .done_id(done_id), .match_cnt(match_cnt)
  );

  // Narrow-counter copy for the saturation case; same stimulus.
  pair_check_scheduler #(.N_REQ(4), .ID_W(2), .BURST(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .req(req), .x_bus(x_bus),
    .gnt(gnt_s), .x_out(x_out_s), .busy(busy_s), .done(done_s), .abort(abort_s),
    .done_id(done_id_s), .match_cnt(match_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  logic [1:0] seq2 [8];
  int         exp_m;
  int         ids[$];
  int         rises[$];
  logic [3:0] gprev;
  logic       bad;

  initial begin
    seq2 = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10};

    // T1 reset with random inputs
    rstn  = 1'b0;
    req   = 4'($urandom);
    x_bus = 8'($urandom);
    tick();
    tick();
    req   = 4'($urandom);
    x_bus = 8'($urandom);
    #1;
    check("t1_gnt", 32'(gnt), 0);
    check("t1_xout", 32'(x_out), 0);
    check("t1_busy", 32'(busy), 0);
    check("t1_done", 32'(done), 0);
    check("t1_abort", 32'(abort), 0);
    check("t1_done_id", 32'(done_id), 0);
    check("t1_match", 32'(match_cnt), 0);
    req  = 4'b0000;
    rstn = 1'b1;
    tick(); tick(); tick();
    check("t1_idle_gnt", 32'(gnt), 0);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_done", 32'(done), 0);

    // T2 single burst for requester 1
    req   = 4'b0010;
    x_bus = 8'h00;
    tick();
    exp_m = 0;
    for (int k = 0; k < 8; k++) begin
      x_bus[3:2] = seq2[k];
      #1;
      check("t2_gnt", 32'(gnt), 32'b0010);
      check("t2_xout", 32'(x_out), 32'(seq2[k]));
      check("t2_busy", 32'(busy), 1);
      check("t2_match_run", 32'(match_cnt), 32'(exp_m));
      if (seq2[k][1] == seq2[k][0]) exp_m++;
      tick();
    end
    check("t2_done", 32'(done), 1);
    check("t2_done_id", 32'(done_id), 1);
    check("t2_abort", 32'(abort), 0);
    check("t2_match", 32'(match_cnt), 4);
    check("t2_gnt_done", 32'(gnt), 0);
    check("t2_xout_done", 32'(x_out), 0);
    check("t2_busy_done", 32'(busy), 0);
    req = 4'b0000;
    tick();
    check("t2_done_low", 32'(done), 0);
    check("t2_match_hold", 32'(match_cnt), 4);

    // T3 round robin with all requesters active
    do_reset();
    req   = 4'b1111;
    x_bus = 8'($urandom);
    gprev = 4'b0000;
    bad   = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if ($countones(gnt) > 1) bad = 1'b1;
      if (gnt != 4'b0000 && gprev == 4'b0000) rises.push_back(c);
      gprev = gnt;
      if (done) ids.push_back(int'(done_id));
    end
    check("t3_onehot", 32'(bad), 0);
    check("t3_n_done", 32'(ids.size()), 5);
    check("t3_n_rise", 32'(rises.size()), 5);
    check("t3_first_rise", 32'(rises.size() > 0 ? rises[0] : -1), 1);
    for (int i = 0; i < ids.size(); i++) check("t3_order", 32'(ids[i]), 32'(i % 4));
    for (int i = 1; i < rises.size(); i++) check("t3_period", 32'(rises[i] - rises[i-1]), 10);

    // T4 abort of requester 2 after three beats
    do_reset();
    req   = 4'b0100;
    x_bus = 8'h00;
    tick();
    check("t4_gnt", 32'(gnt), 32'b0100);
    x_bus[5:4] = 2'b11; tick();
    x_bus[5:4] = 2'b11; tick();
    x_bus[5:4] = 2'b01; tick();
    check("t4_match_run", 32'(match_cnt), 2);
    req        = 4'b0000;
    x_bus[5:4] = 2'b11;
    tick();
    check("t4_done", 32'(done), 1);
    check("t4_abort", 32'(abort), 1);
    check("t4_done_id", 32'(done_id), 2);
    check("t4_match", 32'(match_cnt), 2);
    check("t4_gnt_done", 32'(gnt), 0);
    req = 4'b1001;
    tick();
    check("t4_idle_done", 32'(done), 0);
    check("t4_idle_abort", 32'(abort), 0);
    tick();
    check("t4_next_gnt", 32'(gnt), 32'b1000);

    // T5 saturation on the narrow counter
    do_reset();
    req   = 4'b0001;
    x_bus = 8'hFF;
    tick();
    repeat (8) tick();
    check("t5_done", 32'(done), 1);
    check("t5_match_wide", 32'(match_cnt), 8);
    check("t5_match_sat", 32'(match_cnt_s), 3);
    check("t5_sat_ctrl", 32'({gnt_s, x_out_s, busy_s, done_s, abort_s, done_id_s}),
          32'({4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0}));
    req = 4'b0000;
    tick();

    // T6 reset in the middle of a burst for requester 3
    do_reset();
    req   = 4'b1000;
    x_bus = 8'hC0;
    tick();
    repeat (4) tick();
    check("t6_busy_run", 32'(busy), 1);
    check("t6_gnt_run", 32'(gnt), 32'b1000);
    rstn = 1'b0;
    #1;
    check("t6_gnt_rst", 32'(gnt), 0);
    check("t6_busy_rst", 32'(busy), 0);
    check("t6_xout_rst", 32'(x_out), 0);
    check("t6_match_rst", 32'(match_cnt), 0);
    tick();
    check("t6_no_done_a", 32'(done), 0);
    tick();
    check("t6_no_done_b", 32'(done), 0);
    req  = 4'b1001;
    rstn = 1'b1;
    tick();
    check("t6_first_gnt", 32'(gnt), 32'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
